// File: rtl/dual_issue_scheduler.sv
// Dual-issue scheduler: buffers an instruction stream and issues up to two
// independent ALU instructions per cycle, older one on slot 0.
module dual_issue_scheduler #(
  parameter int DEPTH     = 4,
  parameter int PAIR_WAIT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  output logic        in_ready,
  input  logic        hold,
  input  logic        flush,
  output logic        slot0_valid,
  output logic [31:0] slot0_instr,
  output logic        slot1_valid,
  output logic [31:0] slot1_instr,
  output logic        dep_split,
  output logic [15:0] pair_count,
  output logic [15:0] single_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = (PAIR_WAIT > 0) ? $clog2(PAIR_WAIT + 1) : 1;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;

  typedef enum logic [1:0] {IDLE, WAIT, ISSUE} state_t;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] head, tail, nxt;
  logic [CW-1:0] count, count_n;
  logic [WW-1:0] wcnt, wcnt_n;
  state_t        state, state_n;

  logic       push, pop1, pop2, split;
  logic [1:0] npop;

  logic [6:0] h_op, n_op;
  logic [4:0] h_rd, n_rd, n_rs1, n_rs2;
  logic       h_alu, n_alu, h_wr, raw, waw, pairable;

  assign in_ready = count < CW'(DEPTH);
  assign push     = in_valid && in_ready;
  assign nxt      = head + AW'(1);

  assign h_op  = mem[head][6:0];
  assign h_rd  = mem[head][11:7];
  assign n_op  = mem[nxt][6:0];
  assign n_rd  = mem[nxt][11:7];
  assign n_rs1 = mem[nxt][19:15];
  assign n_rs2 = mem[nxt][24:20];

  assign h_alu = (h_op == OP) || (h_op == OP_IMM) || (h_op == LUI);
  assign n_alu = (n_op == OP) || (n_op == OP_IMM) || (n_op == LUI);
  // x0 destination never creates a hazard
  assign h_wr  = h_alu && (h_rd != 5'd0);
  assign raw   = h_wr &&
                 ((((n_op == OP) || (n_op == OP_IMM)) && (n_rs1 == h_rd)) ||
                  ((n_op == OP) && (n_rs2 == h_rd)));
  assign waw   = h_wr && (n_rd == h_rd);
  assign pairable = h_alu && n_alu && !raw && !waw;

  always_comb begin
    pop1   = 1'b0;
    pop2   = 1'b0;
    split  = 1'b0;
    wcnt_n = wcnt;
    case (state)
      WAIT: begin
        if (!hold) begin
          if (PAIR_WAIT == 0 || wcnt == WW'(PAIR_WAIT)) pop1 = 1'b1;
          else wcnt_n = wcnt + WW'(1);
        end
      end
      ISSUE: begin
        if (!hold) begin
          if (pairable) begin
            pop2 = 1'b1;
          end else begin
            pop1  = 1'b1;
            split = 1'b1;
          end
        end
      end
      default: ;
    endcase
    npop    = pop2 ? 2'd2 : (pop1 ? 2'd1 : 2'd0);
    count_n = count + CW'(push) - CW'(npop);
    unique case (1'b1)
      (count_n == '0):         state_n = IDLE;
      (count_n == CW'(1)):     state_n = WAIT;
      default:                 state_n = ISSUE;
    endcase
    // a fresh lone head always starts its partner wait from zero
    if (state_n != WAIT || state != WAIT || pop1) begin
      if (!(state_n == WAIT && state == WAIT && !pop1)) wcnt_n = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[tail] <= in_instr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      wcnt         <= '0;
      state        <= IDLE;
      slot0_valid  <= 1'b0;
      slot0_instr  <= '0;
      slot1_valid  <= 1'b0;
      slot1_instr  <= '0;
      dep_split    <= 1'b0;
      pair_count   <= '0;
      single_count <= '0;
    end else if (flush) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      wcnt        <= '0;
      state       <= IDLE;
      slot0_valid <= 1'b0;
      slot0_instr <= '0;
      slot1_valid <= 1'b0;
      slot1_instr <= '0;
      dep_split   <= 1'b0;
    end else begin
      if (push) tail <= tail + AW'(1);
      head        <= head + AW'(npop);
      count       <= count_n;
      wcnt        <= wcnt_n;
      state       <= state_n;
      slot0_valid <= pop1 | pop2;
      slot0_instr <= (pop1 | pop2) ? mem[head] : '0;
      slot1_valid <= pop2;
      slot1_instr <= pop2 ? mem[nxt] : '0;
      dep_split   <= split;
      if (pop2) pair_count <= pair_count + 16'd1;
      if (pop1) single_count <= single_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Directed bench for dual_issue_scheduler: PAIR_WAIT=0 vector table plus
// PAIR_WAIT=2 partner-wait, full-buffer and reset sequences.
module tb_dual_issue_scheduler;

  localparam logic [31:0] A1 = 32'h00500093;
  localparam logic [31:0] A2 = 32'h00700113;
  localparam logic [31:0] R  = 32'h001081B3;
  localparam logic [31:0] W1 = 32'h00100213;
  localparam logic [31:0] W2 = 32'h00200213;
  localparam logic [31:0] Z1 = 32'h00000013;
  localparam logic [31:0] Z2 = 32'h000002B3;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, hold, flush;
  logic [31:0] in_instr;

  logic        r0, v00, v01, d0;
  logic [31:0] i00, i01;
  logic [15:0] pc0, sc0;
  logic        r2, v20, v21, d2;
  logic [31:0] i20, i21;
  logic [15:0] pc2, sc2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dual_issue_scheduler #(.DEPTH(4), .PAIR_WAIT(0)) u0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(r0), .hold(hold), .flush(flush),
    .slot0_valid(v00), .slot0_instr(i00),
    .slot1_valid(v01), .slot1_instr(i01),
    .dep_split(d0), .pair_count(pc0), .single_count(sc0)
  );

  dual_issue_scheduler #(.DEPTH(4), .PAIR_WAIT(2)) u2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(r2), .hold(hold), .flush(flush),
    .slot0_valid(v20), .slot0_instr(i20),
    .slot1_valid(v21), .slot1_instr(i21),
    .dep_split(d2), .pair_count(pc2), .single_count(sc2)
  );

  typedef struct {
    logic        h;
    logic        v;
    logic [31:0] ins;
    logic        f;
    logic        s0v;
    logic [31:0] s0i;
    logic        s1v;
    logic [31:0] s1i;
    logic        dep;
  } vec_t;

  vec_t tbl[26];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic h, input logic v, input logic [31:0] ins,
                      input logic f);
    hold     = h;
    in_valid = v;
    in_instr = ins;
    flush    = f;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    hold     = 1'b0;
    in_valid = 1'b0;
    in_instr = '0;
    flush    = 1'b0;
    reset    = 1'b1;
    #3;
    reset    = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{0, 0, 0,  0, 0, 0,  0, 0,  0};
    tbl[1]  = '{0, 1, A1, 0, 0, 0,  0, 0,  0};
    tbl[2]  = '{0, 1, A2, 0, 1, A1, 0, 0,  0};
    tbl[3]  = '{0, 0, 0,  0, 1, A2, 0, 0,  0};
    tbl[4]  = '{0, 0, 0,  0, 0, 0,  0, 0,  0};
    tbl[5]  = '{1, 1, A1, 0, 0, 0,  0, 0,  0};
    tbl[6]  = '{1, 1, A2, 0, 0, 0,  0, 0,  0};
    tbl[7]  = '{0, 0, 0,  0, 1, A1, 1, A2, 0};
    tbl[8]  = '{0, 0, 0,  0, 0, 0,  0, 0,  0};
    tbl[9]  = '{1, 1, A1, 0, 0, 0,  0, 0,  0};
    tbl[10] = '{1, 1, R,  0, 0, 0,  0, 0,  0};
    tbl[11] = '{0, 0, 0,  0, 1, A1, 0, 0,  1};
    tbl[12] = '{0, 0, 0,  0, 1, R,  0, 0,  0};
    tbl[13] = '{0, 0, 0,  0, 0, 0,  0, 0,  0};
    tbl[14] = '{1, 1, W1, 0, 0, 0,  0, 0,  0};
    tbl[15] = '{1, 1, W2, 0, 0, 0,  0, 0,  0};
    tbl[16] = '{0, 0, 0,  0, 1, W1, 0, 0,  1};
    tbl[17] = '{0, 0, 0,  0, 1, W2, 0, 0,  0};
    tbl[18] = '{1, 1, Z1, 0, 0, 0,  0, 0,  0};
    tbl[19] = '{1, 1, Z2, 0, 0, 0,  0, 0,  0};
    tbl[20] = '{0, 0, 0,  0, 1, Z1, 1, Z2, 0};
    tbl[21] = '{1, 1, A1, 0, 0, 0,  0, 0,  0};
    tbl[22] = '{1, 1, A2, 0, 0, 0,  0, 0,  0};
    tbl[23] = '{1, 1, R,  0, 0, 0,  0, 0,  0};
    tbl[24] = '{0, 1, W1, 1, 0, 0,  0, 0,  0};
    tbl[25] = '{0, 0, 0,  0, 0, 0,  0, 0,  0};

    do_reset();
    chk("reset in_ready", 32'(r0), 32'd1);
    chk("reset slot0_valid", 32'(v00), 32'd0);
    chk("reset slot1_valid", 32'(v01), 32'd0);
    chk("reset pair_count", 32'(pc0), 32'd0);
    chk("reset single_count", 32'(sc0), 32'd0);

    for (int i = 0; i < 26; i++) begin
      step(tbl[i].h, tbl[i].v, tbl[i].ins, tbl[i].f);
      chk($sformatf("row%0d s0v", i), 32'(v00), 32'(tbl[i].s0v));
      chk($sformatf("row%0d s0i", i), i00, tbl[i].s0i);
      chk($sformatf("row%0d s1v", i), 32'(v01), 32'(tbl[i].s1v));
      chk($sformatf("row%0d s1i", i), i01, tbl[i].s1i);
      chk($sformatf("row%0d dep", i), 32'(d0), 32'(tbl[i].dep));
    end
    chk("table pair_count", 32'(pc0), 32'd2);
    chk("table single_count", 32'(sc0), 32'd6);

    // lone head waits PAIR_WAIT cycles, then issues single
    do_reset();
    step(0, 1, A1, 0);
    chk("wait e1", 32'(v20), 32'd0);
    step(0, 0, 0, 0);
    chk("wait e2", 32'(v20), 32'd0);
    step(0, 0, 0, 0);
    chk("wait e3", 32'(v20), 32'd0);
    step(0, 0, 0, 0);
    chk("wait issue s0v", 32'(v20), 32'd1);
    chk("wait issue s0i", i20, A1);
    chk("wait issue s1v", 32'(v21), 32'd0);
    chk("wait single_count", 32'(sc2), 32'd1);

    // partner arriving during the wait gets paired
    step(0, 0, 0, 0);
    step(0, 1, A1, 0);
    step(0, 1, A2, 0);
    chk("partner e1", 32'(v20), 32'd0);
    step(0, 0, 0, 0);
    chk("partner s0i", i20, A1);
    chk("partner s1v", 32'(v21), 32'd1);
    chk("partner s1i", i21, A2);
    chk("partner pair_count", 32'(pc2), 32'd1);

    // hold freezes the wait counter
    step(0, 0, 0, 0);
    step(0, 1, W1, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0);
      chk($sformatf("freeze hold%0d", i), 32'(v20), 32'd0);
    end
    step(0, 0, 0, 0);
    chk("freeze r1", 32'(v20), 32'd0);
    step(0, 0, 0, 0);
    chk("freeze r2", 32'(v20), 32'd0);
    step(0, 0, 0, 0);
    chk("freeze issue", i20, W1);
    chk("freeze single_count", 32'(sc2), 32'd2);

    // full buffer drops the fifth word
    do_reset();
    step(1, 1, A1, 0);
    step(1, 1, A2, 0);
    step(1, 1, W1, 0);
    chk("full ready at 3", 32'(r0), 32'd1);
    step(1, 1, Z2, 0);
    chk("full ready at 4", 32'(r0), 32'd0);
    step(1, 1, R, 0);
    chk("full ready after 5th", 32'(r0), 32'd0);
    step(0, 0, 0, 0);
    chk("full p1 s0i", i00, A1);
    chk("full p1 s1i", i01, A2);
    step(0, 0, 0, 0);
    chk("full p2 s0i", i00, W1);
    chk("full p2 s1i", i01, Z2);
    step(0, 0, 0, 0);
    chk("full drained", 32'(v00), 32'd0);
    chk("full pair_count", 32'(pc0), 32'd2);
    chk("full single_count", 32'(sc0), 32'd0);

    // asynchronous reset in the middle of a dual issue
    do_reset();
    step(1, 1, A1, 0);
    step(1, 1, A2, 0);
    step(0, 0, 0, 0);
    chk("pre-reset s0v", 32'(v00), 32'd1);
    chk("pre-reset s1v", 32'(v01), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async s0v", 32'(v00), 32'd0);
    chk("async s1v", 32'(v01), 32'd0);
    chk("async pair_count", 32'(pc0), 32'd0);
    chk("async in_ready", 32'(r0), 32'd1);
    reset = 1'b0;
    step(0, 0, 0, 0);
    chk("post-reset idle", 32'(v00), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
